// File: rtl/store_buffered_dmem.sv
// store_buffered_dmem: word-addressed data memory with a posted-store FIFO, load forwarding and a priority debug write port.
// Optional: define SB_COALESCE_EN to merge stores into a matching buffered entry in place.
module store_buffered_dmem #(
    parameter int ADDR_W   = 8,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_addr2,
    output logic [31:0] read_data2,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        mem_write_enable,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        sb_empty,
    output logic        sb_full,
    output logic        sb_overflow
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]   idx_q  [SB_DEPTH];
    logic [ADDR_W-1:0]   idx_d  [SB_DEPTH];
    logic [31:0]         data_q [SB_DEPTH];
    logic [31:0]         data_d [SB_DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d, ack_q, ack_d;
    logic [31:0]         mem_q [2**ADDR_W];

    logic [ADDR_W-1:0] r_idx, w_idx, d_idx, mem_idx;
    logic [31:0]       mem_wdata;
    logic [PW-1:0]     hit_pos;
    logic              mem_we, drain, full, hit, alloc;
    logic              unused_addr_bits;

    assign r_idx = read_addr2[ADDR_W+1:2];
    assign w_idx = write_addr[ADDR_W+1:2];
    assign d_idx = dbg_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{read_addr2[31:ADDR_W+2], read_addr2[1:0],
                                write_addr[31:ADDR_W+2], write_addr[1:0],
                                dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    assign full        = count_q == CW'(SB_DEPTH);
    assign drain       = (count_q != '0) && !dbg_we;
    assign sb_empty    = count_q == '0;
    assign sb_full     = full;
    assign sb_overflow = ovf_q;
    assign dbg_ack     = ack_q;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        read_data2 = mem_q[r_idx];
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (valid_q[head_q + PW'(k)] && idx_q[head_q + PW'(k)] == r_idx)
                read_data2 = data_q[head_q + PW'(k)];
        end
    end

`ifdef SB_COALESCE_EN
    // A head entry leaving this edge cannot absorb the store.
    always_comb begin
        hit     = 1'b0;
        hit_pos = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (valid_q[k] && idx_q[k] == w_idx && !(drain && PW'(k) == head_q)) begin
                hit     = mem_write_enable;
                hit_pos = PW'(k);
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_pos = '0;
`endif

    always_comb begin
        alloc   = mem_write_enable && !hit && (!full || drain);
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(alloc);
        count_d = count_q + CW'(alloc) - CW'(drain);
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (drain) valid_d[head_q] = 1'b0;
        if (hit) data_d[hit_pos] = write_data;
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            idx_d[tail_q]   = w_idx;
            data_d[tail_q]  = write_data;
        end
        ovf_d     = ovf_q | (mem_write_enable && !hit && !alloc);
        ack_d     = dbg_we;
        mem_we    = dbg_we || drain;
        mem_idx   = dbg_we ? d_idx : idx_q[head_q];
        mem_wdata = dbg_we ? dbg_wdata : data_q[head_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            idx_q   <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end
endmodule

// File: doc/store_buffered_dmem.md
# store_buffered_dmem

Word-addressed data memory for the single-cycle core. Stores are posted into a small FIFO store buffer that drains into the backing array one entry per cycle. Loads are answered combinationally in the same cycle, with forwarding from the youngest matching buffered store. A priority debug/loader write port shares the array write port, and the buffer absorbs the resulting back-pressure.

## Interface
Parameters:
- ADDR_W, 8: word-index width; array holds 2^ADDR_W 32-bit words.
- SB_DEPTH, 4: store-buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- read_addr2  in  32  load byte address.
- read_data2  out  32  load data, combinational.
- write_addr  in  32  store byte address.
- write_data  in  32  store data.
- mem_write_enable  in  1  store request, sampled at rising edge.
- dbg_we  in  1  debug/loader write request; has priority over buffer drain.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_ack  out  1  registered; high the cycle after a sampled dbg_we.
- sb_empty  out  1  buffer holds no entries.
- sb_full  out  1  buffer holds SB_DEPTH entries.
- sb_overflow  out  1  sticky; a store was dropped.

## Operation
- Word index is addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so out-of-range addresses wrap.
- Buffer state:
  - Circular FIFO with head/tail pointers and an occupancy count of width log2(SB_DEPTH)+1.
  - Each entry holds a valid bit, a word index and 32-bit data.
- Push: on a clock edge with mem_write_enable=1, the entry is written at tail and count increments.
- Drain: on a clock edge with count>0 and dbg_we=0, the head entry is written to the array, head advances and count decrements.
- Debug write: on a clock edge with dbg_we=1, dbg_wdata is written to the array at the debug word index, and the drain is suppressed that cycle.
- Push and drain together: count is unchanged, and the push is accepted even when sb_full=1.
- Drop on full: if sb_full=1 and there is no drain that cycle (dbg_we=1), the push is discarded and sb_overflow sets. Only reset clears sb_overflow.
- Load forwarding:
  - read_data2 takes the data of the youngest valid entry whose word index matches read_addr2; otherwise it takes the array word.
  - A store being pushed in the same cycle is not forwarded.
- Ordering: a debug write is not merged into buffered entries. An older buffered store to the same word drains later and overwrites it. Debug writers must wait for sb_empty when ordering matters.
- Reset:
  - Clears pointers, count, valid bits, sb_overflow and dbg_ack.
  - Array contents are not reset.
  - Reset mid-drain discards all pending stores.

## Timing
- Load latency 0: read_data2 is a combinational function of read_addr2, the buffer and the array.
- A store is visible to loads in the cycle after its push edge, via forwarding.
- A store reaches the array at the earliest one edge after its push, when the buffer was empty and dbg_we was low.
- Drain throughput is one entry per cycle. Each cycle with dbg_we=1 delays the drain by one cycle.
- Flag timing: sb_empty, sb_full and sb_overflow are registered/derived from count and valid post-edge.
- Reset values: sb_empty=1, sb_full=0, sb_overflow=0, dbg_ack=0.

## Configuration
- SB_COALESCE_EN defined:
  - A push whose word index matches a valid entry overwrites that entry's data in place. No new entry is allocated, count is unchanged and no overflow occurs, even when full.
  - If the matching entry is the head being drained that same edge, the push allocates a new entry instead.
  - At most one match can exist.
- SB_COALESCE_EN undefined: every push allocates a new entry, and duplicates drain in order.

## Test plan
- Reset, then load 0x10 after a debug write of 0xCAFE0001 to 0x10: dbg_ack pulses the cycle after dbg_we; read_data2=0xCAFE0001; sb_empty=1.
- Single store of 0x11111111 to 0x20 with no debug traffic: sb_empty=0 for one cycle; load of 0x20 returns 0x11111111 both while buffered and after drain; load of 0x22 returns the same value (byte bits ignored).
- Stores to 0x40 of 0xA, then 0xB, in consecutive cycles while dbg_we=1: load of 0x40 returns 0xB. When dbg_we drops, the array ends at 0xB. With SB_COALESCE_EN, count never exceeds 1.
- Hold dbg_we=1 and issue 5 stores to distinct addresses (SB_DEPTH=4): sb_full=1 after the 4th; the 5th is dropped and sb_overflow=1; after release, 4 entries drain in 4 cycles and sb_overflow stays 1.
- Buffer full, dbg_we=0, store issued: drain and push occur together, count stays 4, no overflow.
- Assert reset with 3 pending stores: sb_empty=1 immediately; loads of those addresses return the prior array contents.
